// File: rtl/fuzzy_rule_inference_if.sv
// Handshake and membership bus between the fuzzifier, the rule-inference
// stage and the defuzzifier.
interface fuzzy_rule_inference_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [5*W-1:0] e_mu;
  logic [5*W-1:0] de_mu;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   fuzzy_pl;
  logic [W-1:0]   fuzzy_ps;
  logic [W-1:0]   fuzzy_z;
  logic [W-1:0]   fuzzy_ns;
  logic [W-1:0]   fuzzy_nl;

  modport master (
    output in_valid, e_mu, de_mu, out_ready,
    input  in_ready, out_valid, fuzzy_pl, fuzzy_ps, fuzzy_z, fuzzy_ns, fuzzy_nl
  );

  modport slave (
    input  in_valid, e_mu, de_mu, out_ready,
    output in_ready, out_valid, fuzzy_pl, fuzzy_ps, fuzzy_z, fuzzy_ns, fuzzy_nl
  );
endinterface

// File: rtl/fuzzy_rule_inference.sv
// Sequential min/max evaluation of the 25-rule PD rule base, one rule per
// clock, feeding the five aggregated memberships to the defuzzifier.
module fuzzy_rule_inference #(
  parameter int W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  fuzzy_rule_inference_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    OUT  = 2'd2
  } stateE;

  stateE          stateR;
  stateE          nextStateS;
  logic           inReadyR;
  logic           outValidR;
  logic [2:0]     iR;
  logic [2:0]     jR;
  logic [2:0]     iNextS;
  logic [2:0]     jNextS;
  logic [2:0]     cS;
  logic [5*W-1:0] eMuR;
  logic [5*W-1:0] deMuR;
  logic [W-1:0]   accR     [5];
  logic [W-1:0]   accNextS [5];
  logic [W-1:0]   eSelS;
  logic [W-1:0]   deSelS;
  logic [W-1:0]   strengthS;
  logic           acceptS;
  logic           lastRuleS;

  function automatic logic [W-1:0] selectSet(input logic [5*W-1:0] v, input logic [2:0] idx);
    logic [W-1:0] r;
    case (idx)
      3'd0:    r = v[W-1:0];
      3'd1:    r = v[2*W-1:W];
      3'd2:    r = v[3*W-1:2*W];
      3'd3:    r = v[4*W-1:3*W];
      3'd4:    r = v[5*W-1:4*W];
      default: r = {W{1'b0}};
    endcase
    return r;
  endfunction

  function automatic logic [W-1:0] minW(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [W-1:0] maxW(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Consequent index clamp(i+j-2, 0, 4): 0=NL .. 4=PL, same packing as the inputs.
  function automatic logic [2:0] consequent(input logic [2:0] i, input logic [2:0] j);
    logic [3:0] sum;
    logic [2:0] r;
    sum = {1'b0, i} + {1'b0, j};
    if (sum < 4'd2) begin
      r = 3'd0;
    end else if (sum > 4'd6) begin
      r = 3'd4;
    end else begin
      r = 3'(sum - 4'd2);
    end
    return r;
  endfunction

  // Rule datapath: strength of the current rule and the accumulators it updates.
  always_comb begin
    eSelS     = selectSet(eMuR, iR);
    deSelS    = selectSet(deMuR, jR);
    strengthS = minW(eSelS, deSelS);
    cS        = consequent(iR, jR);
    lastRuleS = (iR == 3'd4) && (jR == 3'd4);
    acceptS   = inReadyR && bus.in_valid;
    if (jR == 3'd4) begin
      jNextS = 3'd0;
      iNextS = iR + 3'd1;
    end else begin
      jNextS = jR + 3'd1;
      iNextS = iR;
    end
    for (int k = 0; k < 5; k++) begin
      if (cS == 3'(k)) begin
        accNextS[k] = maxW(accR[k], strengthS);
      end else begin
        accNextS[k] = accR[k];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    nextStateS = stateR;
    case (stateR)
      IDLE: begin
        if (acceptS) begin
          nextStateS = EVAL;
        end else begin
          nextStateS = IDLE;
        end
      end
      EVAL: begin
        if (lastRuleS) begin
          nextStateS = OUT;
        end else begin
          nextStateS = EVAL;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = OUT;
        end
      end
      default: nextStateS = IDLE;
    endcase
  end

  // State register with handshake flags decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateR    <= IDLE;
      inReadyR  <= 1'b1;
      outValidR <= 1'b0;
    end else begin
      stateR    <= nextStateS;
      inReadyR  <= (nextStateS == IDLE);
      outValidR <= (nextStateS == OUT);
    end
  end

  // Input capture, rule counters and accumulators (which double as the outputs).
  always_ff @(posedge clk) begin
    if (rst) begin
      iR    <= 3'd0;
      jR    <= 3'd0;
      eMuR  <= {(5*W){1'b0}};
      deMuR <= {(5*W){1'b0}};
      for (int k = 0; k < 5; k++) begin
        accR[k] <= {W{1'b0}};
      end
    end else if (acceptS) begin
      iR    <= 3'd0;
      jR    <= 3'd0;
      eMuR  <= bus.e_mu;
      deMuR <= bus.de_mu;
      for (int k = 0; k < 5; k++) begin
        accR[k] <= {W{1'b0}};
      end
    end else if (stateR == EVAL) begin
      iR <= iNextS;
      jR <= jNextS;
      for (int k = 0; k < 5; k++) begin
        accR[k] <= accNextS[k];
      end
    end
  end

  assign bus.in_ready  = inReadyR;
  assign bus.out_valid = outValidR;
  assign bus.fuzzy_nl  = accR[0];
  assign bus.fuzzy_ns  = accR[1];
  assign bus.fuzzy_z   = accR[2];
  assign bus.fuzzy_ps  = accR[3];
  assign bus.fuzzy_pl  = accR[4];

endmodule

// File: doc/fuzzy_rule_inference.md
Name: fuzzy_rule_inference

Overview:
- Inference stage directly upstream of the defuzzifier.
- Takes fuzzified memberships of error (e) and change-of-error (de), five sets each, and evaluates the 25-rule PD rule base sequentially, one rule per clock.
- Uses min for AND and max for aggregation.
- Produces the five aggregated output memberships (PL, PS, Z, NS, NL) with a valid/ready handshake toward the defuzzifier.

Parameters:
- W, 8, membership width in bits (unsigned; all-ones = full membership).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  e_mu/de_mu valid.
- in_ready  output  1  block idle, can accept input.
- e_mu  input  5*W  error memberships; slice k = bits [W*k+W-1 : W*k]; k: 0=NL, 1=NS, 2=Z, 3=PS, 4=PL.
- de_mu  input  5*W  change-of-error memberships, same packing.
- out_valid  output  1  aggregated outputs valid.
- out_ready  input  1  downstream consumed outputs.
- fuzzy_pl  output  W  aggregated PL membership.
- fuzzy_ps  output  W  aggregated PS membership.
- fuzzy_z  output  W  aggregated Z membership.
- fuzzy_ns  output  W  aggregated NS membership.
- fuzzy_nl  output  W  aggregated NL membership.

Behaviour:
- Single clock domain, clk; rst synchronous, active-high, highest priority.
- Reset state: IDLE.
  - in_ready=1, out_valid=0, all fuzzy_* = 0.
  - Rule counters i=j=0; input registers cleared.
- Rule table: rule (i,j) uses e set i and de set j. Consequent index c = clamp(i+j-2, 0, 4).
  - Strength s = min(e_mu[i], de_mu[j]).
  - Accumulator acc[c] <= max(acc[c], s).
  - Equal operands: min(a,a)=a, max(a,a)=a. No arithmetic beyond compare; no overflow possible.
- States: IDLE, EVAL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture e_mu/de_mu into internal registers, clear all five accumulators, set i=j=0, go to EVAL.
  - Input ports are not sampled again until the next IDLE.
- EVAL:
  - in_ready=0. Each clock processes rule (i,j) from the captured registers.
  - Order is j fastest: (0,0),(0,1)..(0,4),(1,0)..(4,4).
  - Rule k is processed at acceptance edge E + 1 + k.
  - After rule (4,4), go to OUT. out_valid=1 from edge E+25 onward, i.e. fixed latency of 25 clocks from acceptance.
- OUT:
  - out_valid=1; fuzzy_* driven from the accumulators and held stable while out_ready=0. No limit on stall length.
  - On out_valid && out_ready: go to IDLE. out_valid drops and in_ready rises on the same edge.
  - fuzzy_* hold their last values until the next acceptance clears them.
- No overlap: in_valid is ignored outside IDLE. Max throughput is one result per 26 clocks with out_ready held high.
- All-zero inputs give all-zero outputs.
  - These are still presented with out_valid=1.
  - The downstream stage owns the zero-sum case.
- Reset mid-EVAL or mid-OUT: on the next edge return to IDLE with reset values. The partial result is discarded and out_valid is never asserted for it.
- Inputs changing during EVAL have no effect on the result.

Test Plan:
1. Reset, then e_mu Z=255 only, de_mu Z=255 only, out_ready=1 -> out_valid exactly 25 clocks after acceptance; fuzzy_z=255, all other outputs 0; in_ready high the following clock.
2. e NS=100, Z=200; de Z=150, PS=50 (others 0) -> fuzzy_ns=100, fuzzy_z=150 (max of 50,150), fuzzy_ps=50, fuzzy_pl=fuzzy_nl=0.
3. Clamp check: e PL=255, NL=30; de PL=80, NL=255 -> fuzzy_pl=80, fuzzy_nl=30, fuzzy_z=min(255,255)=255 via (PL,NL) and (NL,PL); fuzzy_ps=fuzzy_ns=0.
4. Backpressure: hold out_ready=0 for 10 clocks after out_valid -> outputs stable, in_ready=0; a new in_valid pulse in that window is ignored; out_ready=1 -> accepted next, then in_ready=1.
5. Reset asserted at rule 12 of EVAL -> next clock: IDLE, in_ready=1, out_valid=0, fuzzy_*=0; a fresh transaction then produces correct results.
6. Back-to-back: in_valid and out_ready tied high, three random vectors -> results match a reference min/max model, spaced 26 clocks apart.
